// File: rtl/fft_cache_loader.sv
// Copies sample_num words from the sample buffer into the compute cache and flags completion.
// Optional: define FFT_CACHE_LOADER_BITREV_EN to write the cache in bit-reversed address order.
module fft_cache_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              load_to_cache,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              cache_wr_en,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              data_to_cache_loaded,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                         state;
  logic [ADDR_W-1:0]              n_lat;
  logic [ADDR_W-1:0]              rd_cnt;
  logic [RD_LAT-1:0]              vld_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0]  addr_pipe;
  logic                           abort;

`ifdef FFT_CACHE_LOADER_BITREV_EN
  localparam int SH_W = $clog2(ADDR_W + 1);
  logic [SH_W-1:0] rev_sh;

  // Right shift that turns a full-width reversal into a B-bit reversal, B = ceil(log2 n).
  function automatic logic [SH_W-1:0] rev_shift(input logic [ADDR_W-1:0] n);
    int b;
    b = 0;
    for (int i = 0; i < ADDR_W; i++)
      if ((ADDR_W'(1) << i) < n) b = i + 1;
    return SH_W'(ADDR_W - b);
  endfunction

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a,
                                                 input logic [SH_W-1:0]   sh);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r >> sh;
  endfunction
`else
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
    return a;
  endfunction
`endif

  assign abort = ce && !load_to_cache && (state == READ || state == DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      n_lat                <= '0;
      rd_cnt               <= '0;
      vld_pipe             <= '0;
      addr_pipe            <= '0;
      src_rd_en            <= 1'b0;
      src_addr             <= '0;
      cache_wr_en          <= 1'b0;
      cache_addr           <= '0;
      cache_wdata          <= '0;
      data_to_cache_loaded <= 1'b0;
      busy                 <= 1'b0;
`ifdef FFT_CACHE_LOADER_BITREV_EN
      rev_sh               <= '0;
`endif
    end else begin
      // Return path runs every clk so data already in flight is never lost to ce.
      vld_pipe[0]  <= src_rd_en;
`ifdef FFT_CACHE_LOADER_BITREV_EN
      addr_pipe[0] <= map_addr(src_addr, rev_sh);
`else
      addr_pipe[0] <= map_addr(src_addr);
`endif
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      cache_wr_en <= vld_pipe[RD_LAT-1];
      if (vld_pipe[RD_LAT-1]) begin
        cache_addr  <= addr_pipe[RD_LAT-1];
        cache_wdata <= src_rdata;
      end

      case (state)
        IDLE: begin
          src_rd_en <= 1'b0;
          if (ce && load_to_cache) begin
            n_lat  <= sample_num;
            rd_cnt <= '0;
            busy   <= 1'b1;
`ifdef FFT_CACHE_LOADER_BITREV_EN
            rev_sh <= rev_shift(sample_num);
`endif
            state  <= (sample_num == '0) ? DONE : READ;
          end
        end
        READ: begin
          src_rd_en <= ce;
          if (ce) begin
            src_addr <= rd_cnt;
            rd_cnt   <= rd_cnt + 1'b1;
            if (rd_cnt == n_lat - ADDR_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          src_rd_en <= 1'b0;
          // Empty only once the final read has entered and left the delay line.
          if (ce && !src_rd_en && vld_pipe == '0) state <= DONE;
        end
        DONE: begin
          if (ce && !load_to_cache) begin
            data_to_cache_loaded <= 1'b0;
            busy                 <= 1'b0;
            state                <= IDLE;
          end else begin
            data_to_cache_loaded <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        src_rd_en   <= 1'b0;
        vld_pipe    <= '0;
        cache_wr_en <= 1'b0;
      end
    end
  end

endmodule
